// File: rtl/encoder_9b8b_stream.sv
// 9b/8b transmit encoder for the calibration path.
// External byte or pattern burst source, 2-entry output FIFO.
module encoder_9b8b_stream #(
  parameter int          BURST_LEN    = 256,
  parameter logic [7:0]  PATTERN_SEED = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [8:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [8:0]  mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [7:0]  pat;
  logic [15:0] cnt;
  logic        done_q;

  logic        ext_push;
  logic        pat_push;
  logic        push;
  logic        pop;
  logic        start_ok;
  logic        last_word;
  logic        done_set;
  logic [8:0]  wdata;

  function automatic logic [8:0] enc(
    input logic [7:0] d
  );
    logic [3:0] y;
    y = 4'b0000;
    unique case (d[2:0])
      3'b000: y = 4'b1100;
      3'b001: y = 4'b0011;
      3'b010: y = 4'b0101;
      3'b011: y = 4'b1001;
      3'b100: y = 4'b0110;
      3'b101: y = 4'b1010;
      3'b110: y = 4'b0100;
      3'b111: y = 4'b1011;
    endcase
    return {d[7], d[4], y[3:2],
            d[6], d[5], y[1:0], d[3]};
  endfunction

  always_comb begin
    data_ready = rst_n
               && (state == IDLE)
               && (count != 2'd2);
    ext_push  = data_valid && data_ready;
    pat_push  = (state == BURST)
              && (count != 2'd2);
    push      = ext_push || pat_push;
    pop       = (count != 2'd0) && code_ready;
    wdata     = enc(pat_push ? pat : data_in);
    start_ok  = (state == IDLE) && start && mode;
    last_word = cnt == 16'(BURST_LEN - 1);
    done_set  = (state == DRAIN)
              && (count == 2'd1) && pop;
  end

  // Outputs forced low combinationally while reset is held
  always_comb begin
    code_valid = rst_n && (count != 2'd0);
    code_out   = rst_n ? mem[rd_ptr] : 9'd0;
    busy       = rst_n && (state != IDLE);
    done       = rst_n && done_q;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = BURST;
      BURST: if (pat_push && last_word) state_nx = DRAIN;
      DRAIN: if (done_set) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= 9'd0;
      mem[1] <= 9'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      pat    <= PATTERN_SEED;
      cnt    <= 16'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (start_ok) begin
        pat <= PATTERN_SEED;
        cnt <= 16'd0;
      end else if (pat_push) begin
        pat <= pat + 8'd1;
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_encoder_9b8b_stream.sv
// Scoreboard bench for encoder_9b8b_stream.
// Expected words queued at issue; a monitor pops on handshake.
module tb_encoder_9b8b_stream;

  localparam int         BL   = 4;
  localparam logic [7:0] SEED = 8'hFE;

  localparam logic [3:0] YTAB [8] = '{
    4'b1100, 4'b0011, 4'b0101, 4'b1001,
    4'b0110, 4'b1010, 4'b0100, 4'b1011
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [8:0] code_out;
  logic       code_valid;
  logic       code_ready = 1'b0;
  logic       busy;
  logic       done;

  encoder_9b8b_stream #(
    .BURST_LEN(BL),
    .PATTERN_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .start(start),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .code_out(code_out),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [8:0] code;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_hs = -10;
  int         pops = 0;
  int         done_cnt = 0;
  bit         lat_mode = 0;
  bit         fixed_on = 0;
  logic [8:0] fixed_code = 9'd0;
  bit         burst_pending = 0;
  bit         prev_stall = 0;
  logic [8:0] prev_code = 9'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] enc9(input logic [7:0] d);
    logic [3:0] y;
    y = YTAB[d[2:0]];
    return {d[7], d[4], y[3], y[2], d[6], d[5],
            y[1], y[0], d[3]};
  endfunction

  // Returns {found, byte}; found=0 if Y is not a legal code
  function automatic logic [8:0] dec9(input logic [8:0] c);
    logic [2:0] qv;
    logic       ok;
    qv = 3'd0;
    ok = 1'b0;
    for (int i = 0; i < 8; i++)
      if (YTAB[i] == {c[6], c[5], c[2], c[1]}) begin
        qv = 3'(i);
        ok = 1'b1;
      end
    return {ok, c[8], c[4], c[3], c[7], c[0], qv};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready)
      q.push_back('{data_in,
                    fixed_on ? fixed_code : enc9(data_in),
                    cyc, lat_mode});
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && code_valid)
        chk("stall_stable", 32'(code_out), 32'(prev_code));
      if (busy)
        chk("ready_in_burst", 32'(data_ready), 0);
      if (code_valid && code_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %0h required none",
                   code_out);
        end else begin
          e = q.pop_front();
          chk("code", 32'(code_out), 32'(e.code));
          chk("decode", 32'(dec9(code_out)), 32'({1'b1, e.b}));
          if (e.lat) chk("latency", cyc, e.acc + 1);
        end
        pops++;
        last_hs = cyc;
      end
      if (done) begin
        chk("done_expected", 32'(burst_pending), 1);
        chk("done_timing", cyc, last_hs + 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_q_empty", q.size(), 0);
        burst_pending = 0;
        done_cnt++;
      end
      prev_stall = code_valid && !code_ready;
      prev_code  = code_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 0;
    data_valid = 1'b1;
    data_in    = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (data_ready) got = 1;
    end
    if (!got) chk("send_timeout", 0, 1);
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy && !code_valid) ok = 1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    step();
  endtask

  task automatic issue_burst();
    start = 1'b1;
    mode  = 1'b1;
    for (int i = 0; i < BL; i++)
      q.push_back('{SEED + 8'(i), enc9(SEED + 8'(i)), 0, 0});
    burst_pending = 1;
  endtask

  task automatic wait_burst();
    for (int i = 0; i < 200 && burst_pending; i++)
      @(negedge clk);
    if (burst_pending) chk("burst_timeout", 0, 1);
    step();
  endtask

  initial begin
    int d0;
    int p0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_code_valid", 32'(code_valid), 0);
    chk("rst_data_ready", 32'(data_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_code_out", 32'(code_out), 0);
    step();
    rst_n = 1'b1;
    code_ready = 1'b1;
    step();

    lat_mode = 1;
    fixed_on = 1;
    fixed_code = 9'h060;
    send_byte(8'h00);
    fixed_code = 9'h1DF;
    send_byte(8'hFF);
    fixed_code = 9'h14C;
    send_byte(8'hA5);
    fixed_on = 0;
    for (int b = 0; b < 256; b++) send_byte(8'(b));
    lat_mode = 0;
    wait_idle();

    code_ready = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h11;
    @(negedge clk);
    chk("bp_ready_1", 32'(data_ready), 1);
    step();
    data_in = 8'h22;
    @(negedge clk);
    chk("bp_ready_2", 32'(data_ready), 1);
    step();
    data_in = 8'h33;
    repeat (3) begin
      @(negedge clk);
      chk("bp_full", 32'(data_ready), 0);
      step();
    end
    code_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_pop", 32'(data_ready), 0);
    step();
    @(negedge clk);
    chk("bp_reopen", 32'(data_ready), 1);
    step();
    data_valid = 1'b0;
    wait_idle();

    start = 1'b1;
    mode = 1'b0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_mode0", 32'(busy), 0);
    step();

    d0 = done_cnt;
    issue_burst();
    step();
    start = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    wait_burst();
    repeat (5) step();
    chk("done_once", done_cnt, d0 + 1);

    d0 = done_cnt;
    issue_burst();
    for (int i = 1; i < 80 && burst_pending; i++) begin
      step();
      start = (i == 2);
      mode = (i == 2);
      data_valid = (i <= 3);
      data_in = 8'h55;
      code_ready = ~code_ready;
    end
    start = 1'b0;
    mode = 1'b0;
    data_valid = 1'b0;
    code_ready = 1'b1;
    if (burst_pending) chk("stall_burst_timeout", 0, 1);
    wait_idle();
    repeat (4) step();
    chk("stall_done_once", done_cnt, d0 + 1);

    d0 = done_cnt;
    p0 = pops;
    issue_burst();
    step();
    start = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 50 && pops < p0 + 2; i++)
      @(negedge clk);
    step();
    rst_n = 1'b0;
    q.delete();
    burst_pending = 0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(code_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(code_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    repeat (6) step();
    chk("no_done_after_rst", done_cnt, d0);
    issue_burst();
    step();
    start = 1'b0;
    mode = 1'b0;
    wait_burst();
    chk("restart_done", done_cnt, d0 + 1);

    for (int i = 0; i < 400; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      code_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    data_valid = 1'b0;
    code_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
